spi_slave_axis_ingress_sync: RTL

SPI slave receive path (MOSI to AXI-Stream master) running entirely in the system clock domain. It oversamples spi_csn, spi_clk and spi_mosi through synchronizers, shifts MOSI bits on detected SCK rising edges, and assembles bytes. Completed bytes go out on an 8-bit AXIS master, with tuser marking a frame's first (header) byte and tlast marking its final byte. It is the ingress counterpart to the SPI slave egress (MISO) block and feeds the register-file command decoder.

---
 rtl/spi_slave_axis_ingress_sync.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_axis_ingress_sync.sv
// SPI slave ingress: MOSI bits to an 8-bit AXI-Stream master.
// Everything runs on clk; CSN, SCK and MOSI are oversampled.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   spi_csn, spi_clk     chip select (active low) and SCK, mode 0
//   spi_mosi             MOSI_SIZE data lanes
//   m_axis_*             byte stream; tuser = first byte, tlast = last
//   overflow, partial    sticky error flags
//   drop_count           dropped byte count, present only when
//                        SPI_INGRESS_DROP_COUNT_EN is defined
module spi_slave_axis_ingress_sync #(
    parameter int MSB_FIRST   = 1,
    parameter int MOSI_SIZE   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spi_csn,
    input  logic                 spi_clk,
    input  logic [MOSI_SIZE-1:0] spi_mosi,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tuser,
    output logic                 m_axis_tlast,
    output logic                 overflow,
    output logic                 partial
`ifdef SPI_INGRESS_DROP_COUNT_EN
    ,
    output logic [7:0]           drop_count
`endif
);

    localparam int S = SYNC_STAGES;
    localparam logic [2:0] CNT_LAST = 3'(8 / MOSI_SIZE - 1);

    typedef enum logic [1:0] {IDLE, FRAME, FLUSH} state_t;

    state_t state, state_nx;

    // One extra stage on CSN/SCK gives the previous sample for edge detect.
    logic [S:0]                  csn_q;
    logic [S:0]                  sck_q;
    logic [S:0]                  vld_q;
    logic [S-1:0][MOSI_SIZE-1:0] mosi_q;
    logic                        armed;

    logic                 csn_fall, csn_rise, sck_rise;
    logic [MOSI_SIZE-1:0] mosi_s;

    logic       start, shift_en, byte_done, flush;
    logic [2:0] cnt;
    logic [7:0] sh, sh_nx;
    logic       first_flag;

    logic       pend_v, pend_user, pend_last;
    logic [7:0] pend_data;
    logic       out_free, pend_go, drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            csn_q  <= '1;
            sck_q  <= '0;
            vld_q  <= '0;
            mosi_q <= '0;
            armed  <= 1'b0;
        end else begin
            csn_q  <= {csn_q[S-1:0], spi_csn};
            sck_q  <= {sck_q[S-1:0], spi_clk};
            vld_q  <= {vld_q[S-1:0], 1'b1};
            mosi_q <= {mosi_q[S-2:0], spi_mosi};
            // Arm only after a genuine high CSN sample, so a CSN that is
            // already low when reset releases is not taken as a frame start.
            armed  <= armed | (vld_q[S] & csn_q[S-1]);
        end
    end

    assign csn_fall = armed & csn_q[S] & ~csn_q[S-1];
    assign csn_rise = ~csn_q[S] & csn_q[S-1];
    assign sck_rise = sck_q[S-1] & ~sck_q[S];
    assign mosi_s   = mosi_q[S-1];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (csn_fall) state_nx = FRAME;
            FRAME:   if (csn_rise) state_nx = FLUSH;
            FLUSH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start     = (state == IDLE) & csn_fall;
        shift_en  = (state == FRAME) & sck_rise;
        byte_done = shift_en & (cnt == CNT_LAST);
        flush     = (state == FLUSH);
    end

    always_comb begin
        if (MSB_FIRST != 0) sh_nx = {sh[7-MOSI_SIZE:0], mosi_s};
        else                sh_nx = {mosi_s, sh[7:MOSI_SIZE]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sh         <= '0;
            first_flag <= 1'b0;
            partial    <= 1'b0;
        end else if (start) begin
            cnt        <= '0;
            sh         <= '0;
            first_flag <= 1'b1;
        end else if (shift_en) begin
            sh  <= sh_nx;
            cnt <= byte_done ? 3'd0 : cnt + 3'd1;
            if (byte_done) first_flag <= 1'b0;
        end else if (flush) begin
            if (cnt != 3'd0) partial <= 1'b1;
            cnt <= '0;
            sh  <= '0;
        end
    end

    // Pending leaves only once its last-ness is known: a successor byte,
    // the flush itself, or an earlier flush already marked it last.
    assign out_free = ~m_axis_tvalid | m_axis_tready;
    assign pend_go  = pend_v & out_free & (byte_done | flush | pend_last);
    assign drop     = byte_done & pend_v & ~pend_go;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v    <= 1'b0;
            pend_data <= '0;
            pend_user <= 1'b0;
            pend_last <= 1'b0;
            overflow  <= 1'b0;
        end else if (byte_done) begin
            if (drop) begin
                overflow <= 1'b1;
            end else begin
                pend_v    <= 1'b1;
                pend_data <= sh_nx;
                pend_user <= first_flag;
                pend_last <= 1'b0;
            end
        end else if (pend_go) begin
            pend_v    <= 1'b0;
            pend_last <= 1'b0;
        end else if (flush & pend_v) begin
            pend_last <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (pend_go) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= pend_data;
            m_axis_tuser  <= pend_user;
            m_axis_tlast  <= pend_last | flush;
        end else if (m_axis_tvalid & m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef SPI_INGRESS_DROP_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)                          drop_count <= '0;
        else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
`endif

endmodule
